btn_debounce: RTL and testbench

Conditions one raw mechanical input (push-button or slide switch) into a clean, single-clock-domain level plus optional one-cycle edge pulses. It sits directly upstream of the lab flip-flop stage. `level` drives that stage's data input, and `rise`/`fall` can drive its clock-enable or set/reset inputs, so the flip-flop never sees bounce or metastable values. It has a two-flop synchronizer, a stability counter and a four-state FSM.

---
 rtl/lab4_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 38 +++
 rtl/btn_debounce.sv | 143 ++++++++++++++
 tb/tb_btn_debounce.sv | 136 +++++++++++++
 4 files changed

// File: rtl/lab4_pkg.sv
// ---------------------------------------------------------------------------
// lab4_pkg : shared FSM encoding and defaults for the lab input conditioners
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lab4_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    WAIT_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEFAULT_STABLE_CNT = 50000;

  function automatic logic is_wait(input state_t s);
    return (s == WAIT_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer with a configurable reset value
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : synchronizer + stability-counter FSM for one raw input.
// Edge pulses on rise/fall only when DEBOUNCE_PULSE_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import lab4_pkg::*;
#(
  parameter int   CNT_W      = 16,
  parameter int   STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter logic INIT_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  // The entry edge into WAIT is the first of the STABLE_CNT samples, so the
  // change commits when the count already holds STABLE_CNT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam state_t           ST_RST   = INIT_LEVEL ? ST_HIGH : ST_LOW;

  logic s2;

  sync_2ff #(
    .RST_VAL (INIT_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s2)
  );

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             level_d, level_q;
  logic             busy_d, busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      ST_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
    busy_d = is_wait(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level = level_q;
  assign busy  = busy_q;

`ifdef DEBOUNCE_PULSE_EN
  logic rise_d, rise_q;
  logic fall_d, fall_q;

  always_comb begin
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce : directed-vector scoreboard bench for btn_debounce
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btn_debounce;

`ifdef DEBOUNCE_PULSE_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic clk;
  logic reset;
  logic btn_in;
  logic level, rise, fall, busy;

  typedef struct {
    string      name;
    logic [3:0] v;   // {level, busy, rise, fall}
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  btn_debounce #(
    .CNT_W      (4),
    .STABLE_CNT (4),
    .INIT_LEVEL (1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] mk(input logic l, input logic b,
                                    input logic r, input logic f);
    return {l, b, r & PE, f & PE};
  endfunction

  // One call = one clock edge; the expectation describes outputs after it.
  task automatic step(input string nm, input logic b, input logic r,
                      input logic [3:0] e);
    exp_t x;
    @(negedge clk);
    btn_in = b;
    reset  = r;
    x.name = nm;
    x.v    = e;
    exp_q.push_back(x);
  endtask

  task automatic release_seq(input string nm);
    repeat (2) step(nm, 1'b1, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));
    repeat (3) step(nm, 1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0));
    step(nm, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b1, 1'b0));
    repeat (3) step(nm, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  // Monitor: pops one expectation per edge that has one queued
  initial begin
    exp_t       e;
    logic [3:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {level, busy, rise, fall};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: level/busy/rise/fall got %b expected %b at %0t",
                   e.name, act, e.v, $time);
        end
      end
    end
  end

  initial begin
    reset  = 1'b0;
    btn_in = 1'b0;

    repeat (3) step("reset", 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
    repeat (4) step("idle_high", 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));

    // Clean press
    repeat (2) step("press_sync", 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));
    repeat (3) step("press_wait", 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0));
    step("press_fall", 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1));
    repeat (3) step("press_hold", 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));

    release_seq("release1");

    // Bounce: 0,0,1 then 0 held
    step("bounce_e1", 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));
    step("bounce_e2", 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));
    step("bounce_e3", 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0));
    step("bounce_e4", 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0));
    step("bounce_e5", 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));
    repeat (3) step("bounce_wait", 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0));
    step("bounce_fall", 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1));
    repeat (2) step("bounce_hold", 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0));

    release_seq("release2");

    // Reset while a press is pending
    repeat (2) step("rstwait_sync", 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));
    step("rstwait_busy", 1'b0, 1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0));
    step("rstwait_rst", 1'b1, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
    repeat (8) step("rstwait_after", 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b0));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
